// File: rtl/spi_reg_ctrl.sv
// Purpose: command/burst sequencer between the SPI byte engine and the register file.
// Latency: command rx_valid -> reg_rd_en 1 clk; reg_rd_en -> tx_byte valid 2 clk.
// Backpressure: none; the byte engine guarantees >= 4 clk between rx_valid pulses.
//
// Ports:
//   clk, rst_n        system clock, synchronous active-low reset
//   cs_active         synchronised chip select (frame envelope)
//   rx_valid, rx_byte received MOSI byte strobe and data
//   tx_byte           next MISO byte, loaded by the engine when rx_valid=1
//   reg_addr          register bus address (auto-incrementing during bursts)
//   reg_rd_en         one-cycle read strobe; reg_rdata valid the cycle after
//   reg_rdata         register read data
//   reg_wr_en         one-cycle write strobe with reg_wdata
//   busy              frame in progress (state != IDLE)
//   overrun           sticky: a byte arrived before read data was staged
module spi_reg_ctrl #(
  parameter int              ADDR_W     = 7,
  parameter int              DATA_W     = 8,
  parameter logic [DATA_W-1:0] DUMMY_BYTE = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_active,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_byte,
  output logic [DATA_W-1:0] tx_byte,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_rd_en,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              reg_wr_en,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              busy,
  output logic              overrun
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CMD        = 3'd1,
    RD_ISSUE   = 3'd2,
    RD_CAPTURE = 3'd3,
    RD_STREAM  = 3'd4,
    WR_STREAM  = 3'd5
  } state_t;

  state_t state;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      tx_byte   <= DUMMY_BYTE;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_rd_en <= 1'b0;
      reg_wr_en <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      // Strobes are single-cycle by construction: cleared every edge unless re-armed below.
      reg_rd_en <= 1'b0;
      reg_wr_en <= 1'b0;

      // The address advances in the cycle after a write strobe. This is independent of
      // the state so a write that was accepted just before cs dropped still completes.
      if (reg_wr_en) begin
        reg_addr <= reg_addr + ADDR_ONE;
      end

      if (!cs_active) begin
        // Abort from any state; no new strobes are armed here.
        state   <= IDLE;
        busy    <= 1'b0;
        tx_byte <= DUMMY_BYTE;
      end else begin
        case (state)
          IDLE: begin
            // An rx_valid coinciding with frame start is ignored.
            state   <= CMD;
            busy    <= 1'b1;
            overrun <= 1'b0;
            tx_byte <= DUMMY_BYTE;
          end

          CMD: begin
            // tx_byte stays DUMMY so the byte after the command is the read latency byte.
            if (rx_valid) begin
              reg_addr <= rx_byte[ADDR_W-1:0];
              if (rx_byte[7]) begin
                state <= WR_STREAM;
              end else begin
                state     <= RD_ISSUE;
                reg_rd_en <= 1'b1;
              end
            end
          end

          RD_ISSUE: begin
            // reg_rd_en is high during this state; the register file responds next cycle.
            state <= RD_CAPTURE;
            if (rx_valid) begin
              overrun  <= 1'b1;
              reg_addr <= reg_addr + ADDR_ONE;
            end
          end

          RD_CAPTURE: begin
            tx_byte <= reg_rdata;
            state   <= RD_STREAM;
            if (rx_valid) begin
              overrun  <= 1'b1;
              reg_addr <= reg_addr + ADDR_ONE;
            end
          end

          RD_STREAM: begin
            // The engine loads tx_byte on this rx_valid; prefetch the next register.
            if (rx_valid) begin
              reg_addr  <= reg_addr + ADDR_ONE;
              reg_rd_en <= 1'b1;
              state     <= RD_ISSUE;
            end
          end

          WR_STREAM: begin
            tx_byte <= DUMMY_BYTE;
            if (rx_valid) begin
              reg_wr_en <= 1'b1;
              reg_wdata <= rx_byte;
            end
          end

          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
module tb_spi_reg_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cs_active;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic [7:0] tx_byte;
  logic [6:0] reg_addr;
  logic       reg_rd_en;
  logic [7:0] reg_rdata;
  logic       reg_wr_en;
  logic [7:0] reg_wdata;
  logic       busy;
  logic       overrun;

  int total = 0;
  int bad   = 0;

  spi_reg_ctrl #(.ADDR_W(7), .DATA_W(8), .DUMMY_BYTE(8'h00)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cs_active (cs_active),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .tx_byte   (tx_byte),
    .reg_addr  (reg_addr),
    .reg_rd_en (reg_rd_en),
    .reg_rdata (reg_rdata),
    .reg_wr_en (reg_wr_en),
    .reg_wdata (reg_wdata),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Register file model: read data valid the cycle after reg_rd_en.
  logic [7:0] mem [128];

  function automatic logic [7:0] init_val(int a);
    case (a)
      0: return 8'h41;
      1: return 8'h52;
      2: return 8'h47;
      3: return 8'h55;
      4: return 8'h53;
      5: return 8'h01;
      default: return 8'(a) ^ 8'hC3;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 128; i++) mem[i] <= init_val(i);
    end else begin
      if (reg_rd_en) reg_rdata <= mem[reg_addr];
      if (reg_wr_en) mem[reg_addr] <= reg_wdata;
    end
  end

  // Bus monitor, sampled on the falling edge.
  logic [6:0] rd_log [$];
  logic [6:0] wa_log [$];
  logic [7:0] wd_log [$];
  logic [7:0] miso_log [$];
  int         strobe_err = 0;
  logic       prev_rd = 1'b0;

  always @(negedge clk) begin
    if (reg_rd_en === 1'b1) rd_log.push_back(reg_addr);
    if (reg_wr_en === 1'b1) begin
      wa_log.push_back(reg_addr);
      wd_log.push_back(reg_wdata);
    end
    if (rx_valid) miso_log.push_back(tx_byte);
    if (reg_rd_en === 1'b1 && (prev_rd || reg_wr_en === 1'b1)) strobe_err++;
    prev_rd = (reg_rd_en === 1'b1);
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick(1);
    rx_valid = 1'b0;
    tick(5);
  endtask

  task automatic clear_logs();
    rd_log.delete();
    wa_log.delete();
    wd_log.delete();
    miso_log.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cs_active = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
    tick(3);
    total++; if (tx_byte !== 8'h00) begin bad++; $display("FAIL reset_tx got=%h exp=00", tx_byte); end
    total++; if (reg_addr !== 7'h00) begin bad++; $display("FAIL reset_addr got=%h exp=00", reg_addr); end
    total++; if (reg_wdata !== 8'h00) begin bad++; $display("FAIL reset_wdata got=%h exp=00", reg_wdata); end
    total++; if ({reg_rd_en, reg_wr_en} !== 2'b00) begin bad++; $display("FAIL reset_strobes got=%b exp=00", {reg_rd_en, reg_wr_en}); end
    total++; if ({busy, overrun} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {busy, overrun}); end
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_id_burst();
    logic [7:0] exp_miso [7];
    exp_miso = '{8'h00, 8'h41, 8'h52, 8'h47, 8'h55, 8'h53, 8'h01};
    clear_logs();
    cs_active = 1'b1;
    tick(2);
    // First MISO byte is whatever is staged at frame start.
    total++; if (tx_byte !== 8'h00) begin bad++; $display("FAIL id_first_miso got=%h exp=00", tx_byte); end
    send(8'h00);
    for (int i = 0; i < 6; i++) send(8'hFF);
    // Last byte: chip select releases together with its rx_valid, so no further prefetch.
    rx_valid = 1'b1; rx_byte = 8'hFF; cs_active = 1'b0;
    tick(1);
    rx_valid = 1'b0;
    tick(3);
    for (int i = 0; i < 7; i++) begin
      total++;
      if (i >= miso_log.size() || miso_log[i] !== exp_miso[i]) begin
        bad++; $display("FAIL id_miso[%0d] got=%h exp=%h", i, (i < miso_log.size()) ? miso_log[i] : 8'hxx, exp_miso[i]);
      end
    end
    total++; if (rd_log.size() != 7) begin bad++; $display("FAIL id_rd_count got=%0d exp=7", rd_log.size()); end
    for (int i = 0; i < 7 && i < rd_log.size(); i++) begin
      total++; if (rd_log[i] !== 7'(i)) begin bad++; $display("FAIL id_rd_addr[%0d] got=%h exp=%h", i, rd_log[i], 7'(i)); end
    end
    total++; if (wa_log.size() != 0) begin bad++; $display("FAIL id_no_writes got=%0d exp=0", wa_log.size()); end
  endtask

  task automatic test_timing();
    cs_active = 1'b1;
    tick(2);
    rx_valid = 1'b1; rx_byte = 8'h04;
    tick(1);
    rx_valid = 1'b0;
    total++; if (reg_rd_en !== 1'b1 || reg_addr !== 7'h04) begin bad++; $display("FAIL timing_rd_1clk got=%b/%h exp=1/04", reg_rd_en, reg_addr); end
    tick(1);
    total++; if (reg_rd_en !== 1'b0) begin bad++; $display("FAIL timing_rd_single got=%b exp=0", reg_rd_en); end
    total++; if (tx_byte !== 8'h00) begin bad++; $display("FAIL timing_tx_early got=%h exp=00", tx_byte); end
    tick(1);
    total++; if (tx_byte !== 8'h53) begin bad++; $display("FAIL timing_tx_2clk got=%h exp=53", tx_byte); end
    cs_active = 1'b0;
    tick(3);
  endtask

  task automatic test_single_write();
    clear_logs();
    cs_active = 1'b1;
    tick(2);
    send(8'h81);
    send(8'h01);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL wr_busy_high got=%b exp=1", busy); end
    cs_active = 1'b0;
    tick(1);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL wr_busy_drop got=%b exp=0", busy); end
    tick(2);
    total++; if (wa_log.size() != 1) begin bad++; $display("FAIL wr_count got=%0d exp=1", wa_log.size()); end
    else begin
      total++; if (wa_log[0] !== 7'h01 || wd_log[0] !== 8'h01) begin bad++; $display("FAIL wr_addr_data got=%h/%h exp=01/01", wa_log[0], wd_log[0]); end
    end
  endtask

  task automatic test_write_wrap();
    logic [6:0] ea [3];
    logic [7:0] ed [3];
    ea = '{7'h7E, 7'h7F, 7'h00};
    ed = '{8'hAA, 8'hBB, 8'hCC};
    clear_logs();
    cs_active = 1'b1;
    tick(2);
    send(8'hFE);
    send(8'hAA);
    send(8'hBB);
    // Chip select drops the cycle right after the final byte; that write must still land.
    rx_valid = 1'b1; rx_byte = 8'hCC;
    tick(1);
    rx_valid = 1'b0; cs_active = 1'b0;
    tick(4);
    total++; if (wa_log.size() != 3) begin bad++; $display("FAIL wrap_count got=%0d exp=3", wa_log.size()); end
    for (int i = 0; i < 3 && i < wa_log.size(); i++) begin
      total++;
      if (wa_log[i] !== ea[i] || wd_log[i] !== ed[i]) begin
        bad++; $display("FAIL wrap_wr[%0d] got=%h/%h exp=%h/%h", i, wa_log[i], wd_log[i], ea[i], ed[i]);
      end
    end
    total++; if (mem[0] !== 8'hCC) begin bad++; $display("FAIL wrap_mem0 got=%h exp=cc", mem[0]); end
  endtask

  task automatic test_abort_read();
    clear_logs();
    cs_active = 1'b1;
    tick(2);
    rx_valid = 1'b1; rx_byte = 8'h03;
    tick(1);
    rx_valid = 1'b0;
    tick(4);
    cs_active = 1'b0;
    tick(1);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_idle got=%b exp=0", busy); end
    total++; if (tx_byte !== 8'h00) begin bad++; $display("FAIL abort_tx got=%h exp=00", tx_byte); end
    tick(6);
    total++; if (rd_log.size() != 1 || wa_log.size() != 0) begin bad++; $display("FAIL abort_strobes got=%0d/%0d exp=1/0", rd_log.size(), wa_log.size()); end
    clear_logs();
    cs_active = 1'b1;
    tick(2);
    send(8'h82);
    send(8'h5A);
    cs_active = 1'b0;
    tick(2);
    total++;
    if (wa_log.size() != 1 || wa_log[0] !== 7'h02 || wd_log[0] !== 8'h5A) begin
      bad++; $display("FAIL abort_next_cmd got=%0d writes exp=1 write 02=5a", wa_log.size());
    end
  endtask

  task automatic test_overrun();
    cs_active = 1'b1;
    tick(2);
    send(8'h00);
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear_before got=%b exp=0", overrun); end
    rx_valid = 1'b1; rx_byte = 8'hFF;
    tick(1);
    tick(1);
    rx_valid = 1'b0;
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b exp=1", overrun); end
    tick(6);
    cs_active = 1'b0;
    tick(3);
    total++; if (overrun !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL ovr_sticky got=%b/%b exp=1/0", overrun, busy); end
    cs_active = 1'b1;
    tick(1);
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_frame_clear got=%b exp=0", overrun); end
    cs_active = 1'b0;
    tick(2);
  endtask

  task automatic test_reset_midframe();
    clear_logs();
    cs_active = 1'b1;
    tick(2);
    send(8'h90);
    rst_n = 1'b0; rx_valid = 1'b1; rx_byte = 8'h77;
    tick(1);
    rst_n = 1'b1; rx_valid = 1'b0;
    total++; if ({busy, overrun, reg_rd_en, reg_wr_en} !== 4'b0000) begin bad++; $display("FAIL rst_mid_flags got=%b exp=0000", {busy, overrun, reg_rd_en, reg_wr_en}); end
    total++; if (tx_byte !== 8'h00 || reg_addr !== 7'h00 || reg_wdata !== 8'h00) begin bad++; $display("FAIL rst_mid_regs got=%h/%h/%h exp=00/00/00", tx_byte, reg_addr, reg_wdata); end
    cs_active = 1'b0;
    tick(4);
    total++; if (wa_log.size() != 0) begin bad++; $display("FAIL rst_mid_no_write got=%0d exp=0", wa_log.size()); end
  endtask

  task automatic test_strobe_rules();
    total++; if (strobe_err != 0) begin bad++; $display("FAIL strobe_rules got=%0d violations exp=0", strobe_err); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    test_reset();
    test_id_burst();
    test_timing();
    test_single_write();
    test_write_wrap();
    test_abort_read();
    test_overrun();
    test_reset_midframe();
    test_strobe_rules();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
- Transaction controller between the SPI byte engine and the register file.
- Decodes the first byte of each chip-select frame as a command byte: R/W flag plus 7-bit address.
- Sequences burst register reads and writes with address auto-increment.
- Stages read data onto the engine's tx byte. Reads insert one latency byte after the command byte.

Parameters:
- ADDR_W, 7, register address width. Taken from command byte bits [ADDR_W-1:0].
- DATA_W, 8, register and SPI byte width.
- DUMMY_BYTE, 8'h00, value shifted out during the command byte and the read latency byte.

Ports:
- clk  in  1  system clock (12 MHz).
- rst_n  in  1  reset. Synchronous, active-low.
- cs_active  in  1  chip select asserted, already synchronised to clk by the byte engine.
- rx_valid  in  1  one-cycle pulse when a full MOSI byte has been received.
- rx_byte  in  8  received byte. Valid when rx_valid=1.
- tx_byte  out  8  next MISO byte. The engine loads it into its shifter in the cycle rx_valid=1.
- reg_addr  out  ADDR_W  register bus address.
- reg_rd_en  out  1  read strobe. reg_rdata is valid in the cycle after it.
- reg_rdata  in  DATA_W  register read data.
- reg_wr_en  out  1  write strobe, one cycle.
- reg_wdata  out  DATA_W  write data.
- busy  out  1  high when state != IDLE.
- overrun  out  1  sticky error flag. Cleared at frame start.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, tx_byte=DUMMY_BYTE, reg_addr=0, reg_wdata=0, reg_rd_en=0, reg_wr_en=0, busy=0, overrun=0.
- All outputs are registered.
- IDLE:
  - tx_byte=DUMMY_BYTE.
  - cs_active=1 -> CMD; overrun cleared on the same edge.
- CMD:
  - On rx_valid: reg_addr<=rx_byte[ADDR_W-1:0].
  - rx_byte[7]=1 -> WR_STREAM; rx_byte[7]=0 -> RD_ISSUE.
  - tx_byte stays DUMMY_BYTE, so the byte after the command is the latency byte.
- RD_ISSUE:
  - reg_rd_en=1 for exactly one cycle at the current reg_addr -> RD_CAPTURE.
- RD_CAPTURE:
  - tx_byte<=reg_rdata -> RD_STREAM.
- RD_STREAM:
  - On rx_valid (engine loads tx_byte): reg_addr<=reg_addr+1 -> RD_ISSUE.
  - MOSI data is ignored during reads.
- WR_STREAM:
  - On rx_valid: next cycle reg_wr_en=1, reg_wdata=rx_byte, reg_addr=current address.
  - The cycle after the strobe, reg_addr<=reg_addr+1.
  - tx_byte=DUMMY_BYTE.
- Address arithmetic: auto-increment is modulo 2^ADDR_W (0x7F -> 0x00). No saturation.
- Timing:
  - Command-byte rx_valid to first reg_rd_en: 1 cycle.
  - First reg_rd_en to tx_byte valid: 2 cycles.
  - Requires rx_valid spacing >= 4 clk. Guaranteed by SPI timing (8 sclk/byte).
- Overrun:
  - rx_valid in RD_ISSUE or RD_CAPTURE sets overrun=1, sticky until the next frame start.
  - On overrun, the address still increments and the stale tx_byte is used.
- cs_active deasserts in any state:
  - -> IDLE on the next edge; tx_byte<=DUMMY_BYTE.
  - No new strobes, with one exception: a write whose rx_valid preceded the deassert still issues its reg_wr_en.
  - A partial byte never produces rx_valid, so nothing is written for it.
- cs_active and rx_valid in the same cycle in IDLE: the rx_valid is ignored.
- Read strobes are always exactly one cycle. reg_rd_en and reg_wr_en are never high together.
- Reset mid-frame: immediate return to reset values. The frame must be restarted with a new cs assertion.

Test Plan:
- ID burst read:
  - Register model holds 0x00..0x05 = 'A','R','G','U','S',0x01.
  - cs low, send 0x00 then 7x 0xFF.
  - MISO = DUMMY, DUMMY(latency), 0x41,0x52,0x47,0x55,0x53,0x01.
  - reg_rd_en pulses at 0x00..0x06.
- Single write:
  - cs low, send 0x81, 0x01, cs high.
  - Exactly one reg_wr_en with reg_addr=0x01, reg_wdata=0x01.
  - busy drops 1 cycle after cs deasserts.
- Write burst wrap:
  - Send 0xFE, 0xAA, 0xBB, 0xCC.
  - Writes 0x7E=0xAA, 0x7F=0xBB, 0x00=0xCC.
- Abort mid-read:
  - Send 0x03, deassert cs after 3 SPI clocks of the latency byte.
  - State=IDLE, tx_byte=0x00, no further strobes.
  - Next frame decodes its first byte as a command.
- Overrun:
  - Force rx_valid 1 cycle after rx_valid while in RD_STREAM.
  - overrun=1 and stays 1 until the next cs assertion, which clears it.
- Reset:
  - rst_n low for 1 clk during WR_STREAM.
  - All outputs at reset values on the following cycle.
  - No reg_wr_en is issued for the pending byte.
